// File: rtl/pixel_readout_if.sv
// Read port toward the solver result memories plus the outgoing pixel stream.
// The readout drives through 'master'; memory model / display writer sits on 'slave'.
interface pixel_readout_if #(
    parameter int ITER_W = 16,
    parameter int ID_W   = 6,
    parameter int ADDR_W = 19,
    parameter int X_W    = 7,
    parameter int Y_W    = 7
);
    logic [ID_W-1:0]   rd_solver_id;
    logic [ADDR_W-1:0] rd_addr;
    logic [ITER_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [ITER_W-1:0] out_iter;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;

    modport master (
        output rd_solver_id, rd_addr, out_valid, out_x, out_y, out_iter,
               out_sof, out_eol, out_eof,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_solver_id, rd_addr, out_valid, out_x, out_y, out_iter,
               out_sof, out_eol, out_eof,
        output rd_data, out_ready
    );
endinterface

// File: rtl/pixel_readout.sv
// Streams a finished fractal frame out of the solver memories in raster order,
// aligning read latency with a tag pipeline and a credit-protected FWFT FIFO.
module pixel_readout #(
    parameter int NUM_SOLVERS = 1,
    parameter int WIDTH       = 99,
    parameter int HEIGHT      = 66,
    parameter int RD_LATENCY  = 2,
    parameter int ITER_W      = 16,
    parameter int ID_W        = 6,
    parameter int ADDR_W      = 19,
    parameter int X_W         = 7,
    parameter int Y_W         = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            frame_done,
    pixel_readout_if.master bus
);
    localparam int DEPTH   = RD_LATENCY + 2;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PEND_W  = CNT_W + 1;
    localparam int TAG_W   = X_W + Y_W + 3;
    localparam int ENTRY_W = TAG_W + ITER_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state, next_state;
    logic [X_W-1:0]      iss_x;
    logic [Y_W-1:0]      iss_y;
    logic [ID_W-1:0]     sol_cnt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic                last_pixel;
    logic                issue;
    logic                credit_ok;
    logic [TAG_W-1:0]    issue_tag;
    logic [RD_LATENCY-1:0] sr_valid;
    logic [TAG_W-1:0]    sr_tag [RD_LATENCY];
    logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt, in_flight;
    logic [PEND_W-1:0]   pending;
    logic                push, pop;
    logic [ENTRY_W-1:0]  head;
    logic [ENTRY_W-1:0]  push_entry;

    assign last_pixel = (iss_x == X_W'(WIDTH - 1)) && (iss_y == Y_W'(HEIGHT - 1));
    assign issue_tag  = {iss_x, iss_y, (iss_x == '0) && (iss_y == '0),
                         iss_x == X_W'(WIDTH - 1), last_pixel};

    // Reads already in flight hold a reserved FIFO slot, so the FIFO never overflows.
    assign pending    = {1'b0, fifo_cnt} + {1'b0, in_flight};
    assign credit_ok  = pending < PEND_W'(DEPTH);

    assign push       = sr_valid[RD_LATENCY-1];
    assign push_entry = {sr_tag[RD_LATENCY-1][TAG_W-1:3], bus.rd_data, sr_tag[RD_LATENCY-1][2:0]};
    assign head       = fifo_mem[rd_ptr];
    assign pop        = (fifo_cnt != '0) && bus.out_ready;

    assign busy             = (state != IDLE);
    assign bus.rd_solver_id = sol_cnt;
    assign bus.rd_addr      = addr_cnt;
    assign bus.out_valid    = (fifo_cnt != '0);
    assign {bus.out_x, bus.out_y, bus.out_iter, bus.out_sof, bus.out_eol, bus.out_eof} = head;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Counters rest at pixel 0 while idle, so the start cycle itself issues the first read.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    issue      = 1'b1;
                    next_state = last_pixel ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_pixel) next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[0]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || (issue && last_pixel)) begin
            iss_x    <= '0;
            iss_y    <= '0;
            sol_cnt  <= '0;
            addr_cnt <= '0;
        end else if (issue) begin
            if (iss_x == X_W'(WIDTH - 1)) begin
                iss_x <= '0;
                iss_y <= iss_y + Y_W'(1);
            end else begin
                iss_x <= iss_x + X_W'(1);
            end
            if (sol_cnt == ID_W'(NUM_SOLVERS - 1)) begin
                sol_cnt  <= '0;
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end else begin
                sol_cnt  <= sol_cnt + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_valid <= '0;
            for (int k = 0; k < RD_LATENCY; k++) sr_tag[k] <= '0;
        end else begin
            sr_valid[0] <= issue;
            sr_tag[0]   <= issue_tag;
            for (int k = 1; k < RD_LATENCY; k++) begin
                sr_valid[k] <= sr_valid[k-1];
                sr_tag[k]   <= sr_tag[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) fifo_mem[k] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) frame_done <= 1'b0;
        else       frame_done <= (state == DRAIN) && pop && head[0];
    end
endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: a 4x3/2-solver instance and a 5x1/3-solver
// instance, checked beat by beat against a raster-order model of the frame.
module tb_pixel_readout;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, startA, startB, readyA, readyB;
    logic busyA, busyB, doneA, doneB;

    pixel_readout_if busA ();
    pixel_readout_if busB ();

    pixel_readout #(.NUM_SOLVERS(2), .WIDTH(4), .HEIGHT(3), .RD_LATENCY(2), .ITER_W(16),
                    .ID_W(6), .ADDR_W(19), .X_W(7), .Y_W(7)) dutA (
        .clock(clock), .reset(reset), .start(startA), .busy(busyA),
        .frame_done(doneA), .bus(busA.master));

    pixel_readout #(.NUM_SOLVERS(3), .WIDTH(5), .HEIGHT(1), .RD_LATENCY(1), .ITER_W(16),
                    .ID_W(6), .ADDR_W(19), .X_W(7), .Y_W(7)) dutB (
        .clock(clock), .reset(reset), .start(startB), .busy(busyB),
        .frame_done(doneB), .bus(busB.master));

    // Memory model: iteration value is solver*100 + addr, returned after the read latency.
    logic [15:0] pipeA [2];
    logic [15:0] pipeB;
    always @(posedge clock) begin
        pipeA[0] <= 16'(int'(busA.rd_solver_id) * 100 + int'(busA.rd_addr));
        pipeA[1] <= pipeA[0];
        pipeB    <= 16'(int'(busB.rd_solver_id) * 100 + int'(busB.rd_addr));
    end
    assign busA.rd_data   = pipeA[1];
    assign busB.rd_data   = pipeB;
    assign busA.out_ready = readyA;
    assign busB.out_ready = readyB;

    logic        sel;
    logic        obsValid, obsBusy, obsDone;
    logic [32:0] obsBeat;
    logic [24:0] obsRd;
    always_comb begin
        obsValid = sel ? busB.out_valid : busA.out_valid;
        obsBusy  = sel ? busyB : busyA;
        obsDone  = sel ? doneB : doneA;
        obsBeat  = sel ? {busB.out_x, busB.out_y, busB.out_iter, busB.out_sof, busB.out_eol, busB.out_eof}
                       : {busA.out_x, busA.out_y, busA.out_iter, busA.out_sof, busA.out_eol, busA.out_eof};
        obsRd    = sel ? {busB.rd_solver_id, busB.rd_addr} : {busA.rd_solver_id, busA.rd_addr};
    end

    int compared = 0;
    int mismatched = 0;
    int fW, fH, fN, fL;
    int cyc, beatIdx, doneCount, firstValidCyc, firstAccCyc, lastAccCyc;
    logic        curReady, curReset, holdValid;
    logic [32:0] held;
    logic [24:0] lastRd;

    function automatic logic [32:0] expBeat(input int p);
        int x, y, iter;
        x    = p % fW;
        y    = p / fW;
        iter = (p % fN) * 100 + p / fN;
        return {7'(x), 7'(y), 16'(iter), p == 0, x == fW - 1, p == fW * fH - 1};
    endfunction

    function automatic logic [24:0] expRd(input int p);
        return {6'(p % fN), 19'(p / fN)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitorBeat();
        lastRd = obsRd;
        if (holdValid) checkOutput("hold_stable", {obsValid, obsBeat}, {1'b1, held});
        if (obsValid === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
        if (obsValid === 1'b1 && curReady) begin
            checkOutput("extra_beat", 64'(beatIdx >= fW * fH), 0);
            if (beatIdx < fW * fH)
                checkOutput($sformatf("beat%0d", beatIdx), obsBeat, expBeat(beatIdx));
            if (firstAccCyc < 0) firstAccCyc = cyc;
            lastAccCyc = cyc;
            beatIdx++;
        end
        if (obsDone === 1'b1) begin
            doneCount++;
            checkOutput("busy_low_at_done", obsBusy, 0);
        end
        holdValid = (obsValid === 1'b1) && !curReady && !curReset;
        held      = obsBeat;
    endtask

    task automatic applyStimulus(input logic st, input logic rdy, input logic rst);
        reset    = rst;
        curReady = rdy;
        curReset = rst;
        if (sel) begin
            startB = st; readyB = rdy; startA = 1'b0; readyA = 1'b1;
        end else begin
            startA = st; readyA = rdy; startB = 1'b0; readyB = 1'b1;
        end
        #1;
        monitorBeat();
        @(negedge clock);
        cyc++;
    endtask

    task automatic startFrame();
        cyc = 0; beatIdx = 0; doneCount = 0; holdValid = 1'b0;
        firstValidCyc = -1; firstAccCyc = -1; lastAccCyc = -1;
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready, 3: 50-cycle stall then ready
    task automatic runFrame(input int mode, input bit extraStarts, input int maxCycles);
        startFrame();
        for (int c = 0; c < maxCycles; c++) begin
            logic st, rdy;
            st = (c == 0) || (extraStarts && (c == 2 || c == 5 || c == 9));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 4 == 0) || (c % 4 == 3);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (c > 50);
            endcase
            applyStimulus(st, rdy, 1'b0);
            if (mode == 0 && c < fW * fH) checkOutput($sformatf("rd_seq%0d", c), lastRd, expRd(c));
            if (mode == 0 && c == 0) checkOutput("busy_after_start", obsBusy, 1);
            if (mode == 3 && c == 50) begin
                checkOutput("stall_rd_pos", obsRd, expRd(fL + 2));
                checkOutput("stall_no_beats", beatIdx, 0);
                checkOutput("stall_valid", obsValid, 1);
            end
            if (doneCount != 0) break;
        end
        checkOutput("frame_done_once", doneCount, 1);
        checkOutput("beat_count", beatIdx, fW * fH);
        if (mode == 0) checkOutput("first_valid_latency", firstValidCyc, fL + 1);
        if (mode == 0 || mode == 3) checkOutput("gapless", lastAccCyc - firstAccCyc, fW * fH - 1);
    endtask

    initial begin
        sel = 1'b0; reset = 1'b1; startA = 1'b0; startB = 1'b0; readyA = 1'b1; readyB = 1'b1;
        curReady = 1'b1; curReset = 1'b1; holdValid = 1'b0; held = '0; lastRd = '0;
        fW = 4; fH = 3; fN = 2; fL = 2;
        startFrame();
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            #1;
            checkOutput("reset_valid", obsValid, 0);
            checkOutput("reset_busy", obsBusy, 0);
            checkOutput("reset_done", obsDone, 0);
            checkOutput("reset_rd", obsRd, 0);
            checkOutput("reset_fields", obsBeat, 0);
        end
        sel = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] 4x3 frames, two solvers");
        runFrame(0, 1'b1, 100);
        runFrame(0, 1'b0, 100);
        runFrame(1, 1'b0, 200);
        runFrame(3, 1'b0, 200);
        runFrame(2, 1'b0, 400);
        runFrame(2, 1'b1, 400);

        $display("[TB] reset in the middle of a frame");
        startFrame();
        for (int c = 0; c < 100; c++) begin
            applyStimulus(c == 0, 1'b1, 1'b0);
            if (beatIdx == 5) break;
        end
        checkOutput("reached_beat5", beatIdx, 5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_valid", obsValid, 0);
        checkOutput("abort_busy", obsBusy, 0);
        doneCount = 0;
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort_no_done", doneCount, 0);
        runFrame(0, 1'b0, 100);

        $display("[TB] 5x1 frame, three solvers");
        sel = 1'b1;
        fW = 5; fH = 1; fN = 3; fL = 1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        runFrame(0, 1'b0, 100);
        runFrame(2, 1'b0, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pixel_readout.md
Name: pixel_readout

Overview:
- Streams a finished fractal frame out of the solver result memories in raster order, one pixel per beat, with valid/ready backpressure.
- Generalises the pixel iteration and read-latency alignment that the integration bench does by hand. Adds parametrised solver count, frame size, memory read latency and iteration width, plus credit-based flow control and frame markers.
- Sits between multi_solver (read port) and the downstream display/framebuffer writer.

Parameters:
- NUM_SOLVERS, 1, number of solvers; pixels interleave across solvers.
- WIDTH, 99, frame width in pixels.
- HEIGHT, 66, frame height in pixels.
- RD_LATENCY, 2, cycles from rd_addr/rd_solver_id to valid rd_data (>=1).
- ITER_W, 16, width of iteration-count data.
- ID_W, 6, solver id width.
- ADDR_W, 19, per-solver address width.
- X_W, 7, width of out_x. Y_W, 7, width of out_y.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin readout of a new frame (solvers done).
- busy  out  1  high from accepted start until last beat accepted.
- rd_solver_id  out  ID_W  solver select to multi_solver.
- rd_addr  out  ADDR_W  per-solver address to multi_solver.
- rd_data  in  ITER_W  read data, valid RD_LATENCY cycles after the read is issued.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_x  out  X_W  pixel column.
- out_y  out  Y_W  pixel row.
- out_iter  out  ITER_W  iteration count.
- out_sof  out  1  beat is pixel (0,0).
- out_eol  out  1  beat is x==WIDTH-1.
- out_eof  out  1  beat is last pixel of frame.
- frame_done  out  1  one-cycle pulse the cycle after the eof beat is accepted.

Behaviour:
- Reset: busy=0, out_valid=0, frame_done=0, rd_solver_id=0, rd_addr=0, out_x/out_y/out_iter=0, flags=0. All counters, FIFO and in-flight pipeline are cleared. Reset mid-frame aborts the frame and emits no frame_done.
- Pixel mapping: p = y*WIDTH + x; solver = p mod NUM_SOLVERS; addr = p div NUM_SOLVERS. Implemented with counters only, no divider.
  - Solver counter increments per issued read. When it wraps from NUM_SOLVERS-1 to 0, addr increments.
  - x wraps at WIDTH-1 and increments y.
- States: IDLE, ISSUE, DRAIN.
  - IDLE: start=1 → ISSUE, busy=1, counters zeroed. start while busy is ignored.
  - ISSUE: issue one read per cycle when credit is available. After the read for the last pixel is issued → DRAIN.
  - DRAIN: no new reads. When the eof beat handshakes → IDLE, busy=0, frame_done=1 for the next cycle.
- Read pipeline: per-read tag {x, y, sof, eol, eof} is delayed RD_LATENCY cycles in a shift register alongside the read. At the tap, rd_data plus tag are pushed into the output FIFO.
- Output FIFO: depth RD_LATENCY+2; first-word-fall-through.
  - out_valid = FIFO non-empty; pop on out_valid&&out_ready.
- Credit rule: issue a read only if (FIFO occupancy + reads in flight) < depth. The FIFO can never overflow, regardless of out_ready.
  - Simultaneous push and pop in the same cycle leaves occupancy unchanged.
- Throughput: with out_ready held high, one beat per cycle sustained. The first beat's out_valid rises RD_LATENCY+1 cycles after the start cycle. Total frame is WIDTH*HEIGHT beats, no gaps.
- Output fields are stable while out_valid=1 and out_ready=0.
- NUM_SOLVERS=1: rd_solver_id stays 0 and rd_addr=p.
- WIDTH*HEIGHT not a multiple of NUM_SOLVERS: the final addr row is partial; no extra reads are issued.

Test Plan:
- WIDTH=4, HEIGHT=3, NUM_SOLVERS=2, RD_LATENCY=2, memory model returns iter=solver*100+addr, out_ready=1.
  - Start pulse → 12 beats in consecutive cycles, first out_valid 3 cycles after start.
  - Beat p carries iter=(p%2)*100+p/2.
  - sof on beat 0; eol on beats 3, 7, 11; eof on beat 11.
  - frame_done pulses once, busy falls with it.
- Same config, out_ready toggles with pattern 1,0,0,1 repeating → still exactly 12 beats, in order, none duplicated or lost.
  - Outputs are held stable during stalls.
  - Read issue pauses whenever occupancy+in-flight reaches 4.
- out_ready=0 for 50 cycles after start → at most 4 reads issued. Then out_ready=1 → remaining 8 pixels follow at one per cycle.
- NUM_SOLVERS=3, WIDTH=5, HEIGHT=1, RD_LATENCY=1 → rd_solver_id sequence 0,1,2,0,1 and rd_addr sequence 0,0,0,1,1. Exactly 5 reads.
- Reset asserted on beat 5 of the 4x3 frame → next cycle out_valid=0, busy=0, no frame_done. A new start after reset produces a full, correct 12-beat frame starting at sof.
- Start pulses repeated while busy → ignored. A start one cycle after frame_done → a clean second frame with identical contents.
